// File: rtl/boxcar_decimator.sv
// ---------------------------------------------------------------------------
// boxcar_decimator
//   Averaging decimator placed ahead of the extremum finder. Sums 2^L valid
//   input samples, divides by the window length with an arithmetic shift,
//   applies a saturating gain of 2^DC_shift and emits one sample per window
//   as a one-cycle tvalid pulse (no tready).
//
// Ports
//   SYS_aclk       system clock, rising edge
//   SYS_areset     asynchronous active-high reset
//   DC_log_count   log2 of window length, clamped to 16
//   DC_shift       post-average left shift (gain 2^0..2^7), saturating
//   S_AXIS_tdata   signed input sample
//   S_AXIS_tvalid  input qualifier, one sample per edge while high
//   M_AXIS_tdata   signed decimated sample, held between pulses
//   M_AXIS_tvalid  one-cycle pulse per completed window
//   M_AXIS_tuser   saturation flag, qualified by M_AXIS_tvalid
// ---------------------------------------------------------------------------
module boxcar_decimator #(
   parameter int unsigned AXIS_TDATA_WIDTH = 32
) (
   input  logic                        SYS_aclk,
   input  logic                        SYS_areset,
   input  logic [4:0]                  DC_log_count,
   input  logic [2:0]                  DC_shift,
   input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                        S_AXIS_tvalid,
   output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
   output logic                        M_AXIS_tvalid,
   output logic                        M_AXIS_tuser
);

   localparam int unsigned W       = AXIS_TDATA_WIDTH;
   localparam int unsigned GROW_W  = 16;               // headroom for 2^16 samples
   localparam int unsigned ACC_W   = W + GROW_W;
   localparam int unsigned GAIN_W  = 7;                // max DC_shift
   localparam int unsigned SCL_W   = ACC_W + GAIN_W;
   localparam int unsigned CNT_W   = 17;
   localparam int unsigned L_W     = 5;
   localparam int unsigned SH_W    = 3;
   localparam logic [L_W-1:0] L_MAX = L_W'(16);

   // Output saturation limits expressed at the full scaled width
   localparam logic signed [SCL_W-1:0] SAT_MAX = {{(SCL_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [SCL_W-1:0] SAT_MIN = {{(SCL_W-W+1){1'b1}}, {(W-1){1'b0}}};

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic signed [ACC_W-1:0] acc;
   logic        [CNT_W-1:0] count;
   logic        [L_W-1:0]   l_reg;
   logic        [SH_W-1:0]  shift_reg;
   logic signed [ACC_W-1:0] sum;        // completed window total
   logic        [L_W-1:0]   sum_l;      // L the window was captured with
   logic                    done;

   // ------------------------------------------------------------------
   // Combinational helpers (suffixed _c)
   // ------------------------------------------------------------------
   logic        [L_W-1:0]   l_clamp_c;
   logic                    l_change_c;
   logic        [CNT_W-1:0] term_c;
   logic signed [ACC_W-1:0] sample_ext_c;
   logic signed [ACC_W-1:0] sum_next_c;
   logic signed [ACC_W-1:0] mean_c;
   logic signed [SCL_W-1:0] scaled_c;
   logic                    sat_hi_c;
   logic                    sat_lo_c;
   logic        [W-1:0]     out_data_c;

   // Clamp the requested window size and detect a change against the
   // value seen on the previous edge
   always_comb begin
      l_clamp_c  = (DC_log_count > L_MAX) ? L_MAX : DC_log_count;
      l_change_c = (l_clamp_c != l_reg);
   end

   // Terminal count 2^L - 1; l_reg equals l_clamp_c whenever it is used
   always_comb begin
      term_c = CNT_W'((CNT_W'(1) << l_reg) - CNT_W'(1));
   end

   // Sign-extended running sum including the sample on this edge
   always_comb begin
      sample_ext_c = {{GROW_W{S_AXIS_tdata[W-1]}}, S_AXIS_tdata};
      sum_next_c   = ACC_W'(acc + sample_ext_c);
   end

   // Average (floor) then gain at full width, then saturate to W bits
   always_comb begin
      mean_c     = sum >>> sum_l;
      scaled_c   = SCL_W'({{GAIN_W{mean_c[ACC_W-1]}}, mean_c} << shift_reg);
      sat_hi_c   = (scaled_c > SAT_MAX);
      sat_lo_c   = (scaled_c < SAT_MIN);
      out_data_c = W'(scaled_c);
      if (sat_hi_c) begin
         out_data_c = W'(SAT_MAX);
      end else if (sat_lo_c) begin
         out_data_c = W'(SAT_MIN);
      end
   end

   // ------------------------------------------------------------------
   // Configuration registers, sampled every edge
   // ------------------------------------------------------------------
   always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
      if (SYS_areset) begin
         l_reg     <= '0;
         shift_reg <= '0;
      end else begin
         l_reg     <= l_clamp_c;
         shift_reg <= DC_shift;
      end
   end

   // ------------------------------------------------------------------
   // Accumulator, sample counter and window capture
   // ------------------------------------------------------------------
   always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
      if (SYS_areset) begin
         acc   <= '0;
         count <= '0;
         sum   <= '0;
         sum_l <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (l_change_c) begin
            // Window size changed: drop the partial window and this sample
            acc   <= '0;
            count <= '0;
         end else if (S_AXIS_tvalid) begin
            if (count == term_c) begin
               sum   <= sum_next_c;
               sum_l <= l_reg;
               done  <= 1'b1;
               acc   <= '0;
               count <= '0;
            end else begin
               acc   <= sum_next_c;
               count <= CNT_W'(count + CNT_W'(1));
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Output stage: one pulse the edge after a window completes
   // ------------------------------------------------------------------
   always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
      if (SYS_areset) begin
         M_AXIS_tdata  <= '0;
         M_AXIS_tvalid <= 1'b0;
         M_AXIS_tuser  <= 1'b0;
      end else begin
         M_AXIS_tvalid <= done;
         if (done) begin
            M_AXIS_tdata <= out_data_c;
            M_AXIS_tuser <= sat_hi_c | sat_lo_c;
         end
      end
   end

endmodule

// File: tb/tb_boxcar_decimator.sv
// ---------------------------------------------------------------------------
// tb_boxcar_decimator
//   Directed self-checking bench for boxcar_decimator. Inputs change 1 time
//   unit after each rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_boxcar_decimator;

   localparam int unsigned W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 64'sd1;

   logic                clk;
   logic                rst;
   logic [4:0]          log_count;
   logic [2:0]          shift;
   logic signed [W-1:0] s_tdata;
   logic                s_tvalid;
   logic [W-1:0]        m_tdata;
   logic                m_tvalid;
   logic                m_tuser;

   int                  total;
   int                  bad;
   int                  pulses;
   logic signed [W-1:0] last_data;
   logic                last_user;

   boxcar_decimator #(.AXIS_TDATA_WIDTH(W)) dut (
      .SYS_aclk      (clk),
      .SYS_areset    (rst),
      .DC_log_count  (log_count),
      .DC_shift      (shift),
      .S_AXIS_tdata  (s_tdata),
      .S_AXIS_tvalid (s_tvalid),
      .M_AXIS_tdata  (m_tdata),
      .M_AXIS_tvalid (m_tvalid),
      .M_AXIS_tuser  (m_tuser)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, wait for the edge, then record any output pulse
   task automatic cyc(input logic v, input logic signed [W-1:0] d);
      s_tvalid = v;
      s_tdata  = d;
      @(posedge clk);
      #1;
      if (m_tvalid) begin
         pulses++;
         last_data = $signed(m_tdata);
         last_user = m_tuser;
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      pulses    = 0;
      last_data = '0;
      last_user = 1'b0;
      rst       = 1'b1;
      log_count = 5'd2;
      shift     = 3'd0;
      s_tdata   = '0;
      s_tvalid  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tdata", longint'($signed(m_tdata)), 0);
      chk("rst_tvalid", longint'(m_tvalid), 0);
      chk("rst_tuser", longint'(m_tuser), 0);
      rst = 1'b0;
      cyc(1'b0, 0);                     // internal L moves 0 -> 2

      // Window averaging: (4+8-4+12)/4 = 5
      pulses = 0;
      cyc(1'b1, 4);
      cyc(1'b1, 8);
      cyc(1'b1, -4);
      cyc(1'b1, 12);
      chk("avg_no_early_pulse", pulses, 0);
      cyc(1'b0, 0);
      chk("avg_pulse_count", pulses, 1);
      chk("avg_tdata", last_data, 5);
      chk("avg_tuser", last_user, 0);
      cyc(1'b0, 0);
      chk("avg_pulse_width", longint'(m_tvalid), 0);
      chk("avg_tdata_held", longint'($signed(m_tdata)), 5);
      // Next window starts from zero: (1+1+1+1)/4 = 1
      cyc(1'b1, 1);
      cyc(1'b1, 1);
      cyc(1'b1, 1);
      cyc(1'b1, 1);
      cyc(1'b0, 0);
      chk("avg2_pulse_count", pulses, 2);
      chk("avg2_tdata", last_data, 1);

      // Negative rounding with a gap: floor(-3/2) = -2
      log_count = 5'd1;
      cyc(1'b0, 0);
      pulses = 0;
      cyc(1'b1, -1);
      cyc(1'b0, 0);
      cyc(1'b0, 0);
      cyc(1'b0, 0);
      chk("gap_no_pulse", pulses, 0);
      cyc(1'b1, -2);
      cyc(1'b0, 0);
      chk("gap_pulse_count", pulses, 1);
      chk("gap_tdata", last_data, -2);

      // Saturation and gain, L=0 pass-through
      log_count = 5'd0;
      shift     = 3'd7;
      cyc(1'b0, 0);
      pulses = 0;
      cyc(1'b1, 32'sh4000_0000);
      cyc(1'b0, 0);
      chk("sat_hi_tdata", last_data, SMAX);
      chk("sat_hi_tuser", last_user, 1);
      cyc(1'b1, 32'shC000_0000);
      cyc(1'b0, 0);
      chk("sat_lo_tdata", last_data, SMIN);
      chk("sat_lo_tuser", last_user, 1);
      cyc(1'b1, 3);
      cyc(1'b0, 0);
      chk("gain_tdata", last_data, 384);
      chk("gain_tuser", last_user, 0);
      chk("sat_pulse_count", pulses, 3);
      // Continuous tvalid at L=0 gives a pulse every cycle
      shift = 3'd1;
      cyc(1'b0, 0);
      pulses = 0;
      cyc(1'b1, 10);
      cyc(1'b1, -6);
      chk("l0_back2back_tvalid", longint'(m_tvalid), 1);
      chk("l0_back2back_tdata", last_data, 20);
      cyc(1'b0, 0);
      chk("l0_back2back_tdata2", last_data, -12);
      chk("l0_back2back_count", pulses, 2);

      // Config change mid-window: (10+20)/2 = 15, old window and 4th sample lost
      log_count = 5'd3;
      shift     = 3'd0;
      cyc(1'b0, 0);
      pulses = 0;
      cyc(1'b1, 1);
      cyc(1'b1, 2);
      cyc(1'b1, 3);
      log_count = 5'd1;
      cyc(1'b1, 100);
      cyc(1'b1, 10);
      cyc(1'b1, 20);
      cyc(1'b0, 0);
      cyc(1'b0, 0);
      chk("cfg_pulse_count", pulses, 1);
      chk("cfg_tdata", last_data, 15);

      // Reset mid-window
      log_count = 5'd2;
      cyc(1'b0, 0);
      pulses = 0;
      cyc(1'b1, 100);
      cyc(1'b1, 100);
      s_tvalid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_tdata", longint'($signed(m_tdata)), 0);
      chk("arst_tvalid", longint'(m_tvalid), 0);
      chk("arst_tuser", longint'(m_tuser), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(1'b0, 0);                     // internal L moves 0 -> 2
      cyc(1'b1, 1);
      cyc(1'b1, 1);
      cyc(1'b1, 1);
      cyc(1'b1, 1);
      cyc(1'b0, 0);
      chk("arst_pulse_count", pulses, 1);
      chk("arst_post_tdata", last_data, 1);

      // Clamp: L=20 acts as 16
      log_count = 5'd20;
      cyc(1'b0, 0);
      pulses = 0;
      for (int i = 0; i < 65536; i++) begin
         cyc(1'b1, 7);
      end
      chk("clamp_no_early_pulse", pulses, 0);
      cyc(1'b0, 0);
      chk("clamp_pulse_count", pulses, 1);
      chk("clamp_tdata", last_data, 7);
      chk("clamp_tuser", last_user, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/boxcar_decimator.md
# boxcar_decimator

Averaging decimator that sits directly upstream of the extremum finder. It sums 2^DC_log_count valid input samples, divides by the window length with an arithmetic shift, and applies a saturating gain of 2^DC_shift. It then emits one sample per window on an AXI-Stream-style output that has tvalid and no tready. Its purpose is to reduce the sample rate and noise before min/max detection.

## Interface
- AXIS_TDATA_WIDTH, 32: width of input and output sample words (signed two's complement).
- SYS_aclk  input  1  system clock; all logic is on the rising edge.
- SYS_areset  input  1  reset; one clock, reset is asynchronous and active-high.
- DC_log_count  input  5  log2 of the window length; values above 16 are clamped to 16.
- DC_shift  input  3  post-average left shift (gain 2^0..2^7), saturating.
- S_AXIS_tdata  input  AXIS_TDATA_WIDTH  input sample, signed.
- S_AXIS_tvalid  input  1  input qualifier; a sample is accepted on every edge where this is high.
- M_AXIS_tdata  output  AXIS_TDATA_WIDTH  decimated sample, signed.
- M_AXIS_tvalid  output  1  one-cycle pulse per completed window.
- M_AXIS_tuser  output  1  saturation flag; qualified by M_AXIS_tvalid.

## Operation
- Accumulator: signed, AXIS_TDATA_WIDTH+16 bits. It cannot overflow at the maximum window of 2^16 samples.
- Sample counter: 17 bits, counts accepted samples in the current window. Terminal count is 2^L - 1, where L is the clamped log count.
- Edge with S_AXIS_tvalid=1 and count < terminal count: acc <= acc + tdata (sign-extended); count increments.
- Edge with S_AXIS_tvalid=1 and count = terminal count:
  - The pipeline register captures sum = acc + tdata.
  - The done flag is set.
  - acc <= 0 and count <= 0.
- Edge with S_AXIS_tvalid=0: acc and count hold.
- L=0: every accepted sample is a complete window (pass-through with gain).
- Output stage, on the edge after done:
  - mean = sum >>> L (arithmetic, rounds toward negative infinity).
  - scaled = mean <<< DC_shift, computed at full width.
  - If scaled > 2^(W-1)-1, M_AXIS_tdata = 2^(W-1)-1 and tuser = 1.
  - If scaled < -2^(W-1), M_AXIS_tdata = -2^(W-1) and tuser = 1.
  - Otherwise M_AXIS_tdata = scaled and tuser = 0.
  - M_AXIS_tvalid = 1 for exactly that one cycle.
- DC_log_count and DC_shift are sampled into internal registers every edge.
- Change of clamped L between consecutive edges:
  - The partial window is discarded (acc <= 0, count <= 0).
  - The sample accepted on that same edge is also discarded.
  - A window completed in the pipeline on the previous edge still emits normally, using the L it was captured with.
- DC_shift change: takes effect on the next output computation. The window is not restarted.
- M_AXIS_tdata holds its last value between pulses. M_AXIS_tuser holds too but is meaningful only with tvalid.

## Timing
- Reset (asynchronous assert, synchronous-release use):
  - acc, count and done are 0.
  - M_AXIS_tdata = 0, M_AXIS_tvalid = 0, M_AXIS_tuser = 0.
  - Internal L and shift registers are 0.
- Reset mid-window discards the partial sum. A pending done is cancelled, and no tvalid is produced for it.
- Latency: the final sample of a window is accepted at edge E, and M_AXIS_tvalid is high from edge E+1 to E+2.
- Throughput: one output per 2^L accepted samples. With L=0 and continuous tvalid, M_AXIS_tvalid is high every cycle.
- Gaps in S_AXIS_tvalid stretch the window; they never shorten it or emit early.
- Window boundaries are counted from reset or from the last L change. There is no alignment to an external strobe.

## Test plan
- Window averaging, continuous tvalid:
  - Stimulus: L=2, shift=0, inputs 4, 8, -4, 12.
  - Required: a single tvalid pulse one cycle after the 12 is accepted, tdata=5, tuser=0, then the next window starts cleanly.
- Negative rounding and gaps:
  - Stimulus: L=1, inputs -1, (tvalid low for 3 cycles), -2.
  - Required: one pulse with tdata=-2, and no pulse during the gap.
- Saturation:
  - Stimulus: L=0, shift=7, input 2^30.
  - Required: tdata=2^31-1, tuser=1.
  - Stimulus: input -2^30.
  - Required: tdata=-2^31, tuser=1.
  - Stimulus: input 3.
  - Required: tdata=384, tuser=0.
- Config change mid-window:
  - Stimulus: L=3; feed 3 samples, then set L=1 on the edge carrying a 4th sample; then feed 10 and 20.
  - Required: no output from the old window, the 4th sample is discarded, then exactly one pulse with tdata=15.
- Reset mid-operation:
  - Stimulus: L=2; feed 2 samples of 100, assert SYS_areset asynchronously between edges, release, then feed 1, 1, 1, 1.
  - Required: all outputs 0 immediately on assert, then one pulse with tdata=1.
- Clamp:
  - Stimulus: DC_log_count=20 with constant input 7.
  - Required: the first pulse arrives after exactly 65536 accepted samples, with tdata=7.
